// File: rtl/frame_crc_packer.sv
// Frame builder for the whitening stage: start mark, preamble, payload, CRC-16/CCITT-FALSE, end mark.
// The FSM state names the kind of byte currently on dout; din_ready is the only unregistered output.
module frame_crc_packer #(
    parameter int unsigned  PAD_LEN  = 80,
    parameter logic [7:0]   PAD_BYTE = 8'hAA,
    parameter int unsigned  MAX_LEN  = 255,
    parameter logic [15:0]  CRC_INIT = 16'hFFFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] din,
    input  logic       din_valid,
    input  logic       din_last,
    output logic       din_ready,
    output logic [7:0] dout,
    output logic       next_indicator,
    output logic       busy,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MARK,
        S_PAD,
        S_PAYLOAD,
        S_CRC_HI,
        S_CRC_LO,
        S_END
    } state_t;

    localparam logic [15:0] PAD_LAST = 16'(PAD_LEN - 1);
    localparam logic [15:0] MAX_LAST = 16'(MAX_LEN - 1);

    state_t      state_q, state_d;
    logic [15:0] pad_cnt_q, pad_cnt_d;
    logic [15:0] byte_cnt_q, byte_cnt_d;
    logic [15:0] crc_q, crc_d;
    logic        last_q, last_d;
    logic        ovf_q, ovf_d;
    logic [7:0]  dout_q, dout_d;
    logic        ind_q, ind_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
    logic        final_byte;

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) begin
            r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        end
        return r;
    endfunction

    // Ready in the final preamble cycle so the first payload byte follows the preamble with no gap.
    assign din_ready = ((state_q == S_PAD) && (pad_cnt_q == PAD_LAST)) ||
                       ((state_q == S_PAYLOAD) && !last_q);

    assign final_byte = din_last || (byte_cnt_q == MAX_LAST);

    always_comb begin
        state_d    = state_q;
        pad_cnt_d  = pad_cnt_q;
        byte_cnt_d = byte_cnt_q;
        crc_d      = crc_q;
        last_d     = last_q;
        ovf_d      = ovf_q;
        dout_d     = 8'h00;
        ind_d      = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !busy_q) begin
                    state_d    = S_MARK;
                    ind_d      = 1'b1;
                    pad_cnt_d  = 16'd0;
                    byte_cnt_d = 16'd0;
                    crc_d      = CRC_INIT;
                    last_d     = 1'b0;
                    ovf_d      = 1'b0;
                end
            end
            S_MARK: begin
                state_d = S_PAD;
                dout_d  = PAD_BYTE;
            end
            S_PAD, S_PAYLOAD: begin
                if ((state_q == S_PAD) && (pad_cnt_q != PAD_LAST)) begin
                    pad_cnt_d = pad_cnt_q + 16'd1;
                    dout_d    = PAD_BYTE;
                end else if ((state_q == S_PAYLOAD) && last_q) begin
                    state_d = S_CRC_HI;
                    dout_d  = crc_q[15:8];
                end else if (din_valid) begin
                    state_d    = S_PAYLOAD;
                    dout_d     = din;
                    crc_d      = crc_byte(crc_q, din);
                    byte_cnt_d = byte_cnt_q + 16'd1;
                    last_d     = final_byte;
                    ovf_d      = !din_last && (byte_cnt_q == MAX_LAST);
                end else begin
                    // Underrun: close the frame immediately without CRC bytes.
                    state_d = S_END;
                    ind_d   = 1'b1;
                    err_d   = 1'b1;
                end
            end
            S_CRC_HI: begin
                state_d = S_CRC_LO;
                dout_d  = crc_q[7:0];
            end
            S_CRC_LO: begin
                state_d = S_END;
                ind_d   = 1'b1;
                err_d   = ovf_q;
            end
            S_END: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pad_cnt_q  <= 16'd0;
            byte_cnt_q <= 16'd0;
            crc_q      <= CRC_INIT;
            last_q     <= 1'b0;
            ovf_q      <= 1'b0;
            dout_q     <= 8'h00;
            ind_q      <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pad_cnt_q  <= pad_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            crc_q      <= crc_d;
            last_q     <= last_d;
            ovf_q      <= ovf_d;
            dout_q     <= dout_d;
            ind_q      <= ind_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign dout           = dout_q;
    assign next_indicator = ind_q;
    assign busy           = busy_q;
    assign err            = err_q;

endmodule
